// File: rtl/btn_pkg.sv
// btn_pkg: timing and width helpers shared by the button input array.
// Provides cycle-count conversions from clock frequency, counter width
// sizing and the released-pin level for a given polarity.
package btn_pkg;

    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int debounce_cycles(input longint freq, input longint us);
        longint c = freq * us / 64'd1_000_000;
        return (c < 1) ? 1 : int'(c);
    endfunction

    function automatic int ms_cycles(input longint freq);
        return (freq < 1000) ? 1 : int'(freq / 1000);
    endfunction

    // Pin level when the button is released: high for active-low wiring.
    function automatic logic idle_pin(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debounce filter and hold/repeat timer for one button.
// Ports: clk, reset (sync, active-high), raw_i (async pin), ms_tick_i (shared
// 1 ms strobe); level_o (debounced, 1 = pressed), press_o, release_o, long_o,
// repeat_o (one-cycle event pulses).
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = 10,
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic ms_tick_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);
    localparam int CW = width_for(DB_CYCLES);
    localparam int HW = width_for(LONG_MS > REPEAT_MS ? LONG_MS : REPEAT_MS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_MS);
    localparam logic [HW-1:0] HOLD_REP  = HW'(REPEAT_MS);
    localparam logic IDLE = idle_pin(ACTIVE_LOW);
    localparam bit REP_EN = REPEAT_MS != 0;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic level_q, level_d, long_done_q, long_done_d;
    logic press_q, press_d, release_q, release_d, long_q, long_d, repeat_q, repeat_d;
    logic s, settled, held;

    always_comb begin
        s           = sync_q[1] ^ ACTIVE_LOW;
        settled     = (s != level_q) && (cnt_q == CNT_LAST);
        cnt_d       = (s == level_q || settled) ? '0 : cnt_q + 1'b1;
        level_d     = settled ? s : level_q;
        press_d     = settled && s;
        release_d   = settled && !s;
        // Timer only runs across edges where the button stays down, so a
        // release landing on a threshold tick suppresses the pulse.
        held        = level_q && level_d;
        // Freeze once long fired with repeat disabled so hold never wraps.
        hold_inc    = hold_q + HW'(ms_tick_i && !(long_done_q && !REP_EN));
        long_d      = held && !long_done_q && hold_inc == HOLD_LONG;
        repeat_d    = held && long_done_q && REP_EN && hold_inc == HOLD_REP;
        long_done_d = held && (long_done_q || long_d);
        hold_d      = (!held || long_d || repeat_d) ? '0 : hold_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= {2{IDLE}};
            cnt_q       <= '0;
            hold_q      <= '0;
            level_q     <= 1'b0;
            long_done_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], raw_i};
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            level_q     <= level_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_input_array.sv
// btn_input_array: NUM_BTNS independent debounced button channels sharing a 1 ms timebase.
// Ports: clk, reset (sync, active-high), btn_raw (async pins); btn_level
// (debounced, 1 = pressed), press_pulse, release_pulse, long_pulse,
// repeat_pulse (one-cycle events, one bit per channel).
module btn_input_array
    import btn_pkg::*;
#(
    parameter int NUM_BTNS      = 4,
    parameter int CLKIN_FREQ    = 27_000_000,
    parameter int DEBOUNCE_US   = 1000,
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] press_pulse,
    output logic [NUM_BTNS-1:0] release_pulse,
    output logic [NUM_BTNS-1:0] long_pulse,
    output logic [NUM_BTNS-1:0] repeat_pulse
);
    localparam int DB_CYC = debounce_cycles(CLKIN_FREQ, DEBOUNCE_US);
    localparam int MS_CYC = ms_cycles(CLKIN_FREQ);
    localparam int PW     = width_for(MS_CYC - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(MS_CYC - 1);

    logic [PW-1:0] pre_q;
    logic          ms_tick;

    assign ms_tick = pre_q == PRE_LAST;

    always_ff @(posedge clk) begin
        if (reset) pre_q <= '0;
        else       pre_q <= ms_tick ? '0 : pre_q + 1'b1;
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES (DB_CYC),
            .LONG_MS   (LONG_PRESS_MS),
            .REPEAT_MS (REPEAT_MS),
            .ACTIVE_LOW(ACTIVE_LOW != 0)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (btn_raw[i]),
            .ms_tick_i(ms_tick),
            .level_o  (btn_level[i]),
            .press_o  (press_pulse[i]),
            .release_o(release_pulse[i]),
            .long_o   (long_pulse[i]),
            .repeat_o (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_input_array.sv
// tb_btn_input_array: directed and randomized checks of btn_input_array against a run-length/tick-count model.
module tb_btn_input_array;
    localparam int N = 4, DB = 10, MS = 10, LONG = 5, REP = 2;

    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] btn_raw = '1;
    logic [N-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic [5*N-1:0] obs, exp_v;
    int total = 0, bad = 0;

    logic [N-1:0] m_d1, m_d2, m_prev_s, m_level, m_press, m_rel, m_long, m_rep;
    int m_run[N], m_ticks[N], m_k;

    always #5 clk = ~clk;

    btn_input_array #(
        .NUM_BTNS(N), .CLKIN_FREQ(10_000), .DEBOUNCE_US(1000),
        .LONG_PRESS_MS(LONG), .REPEAT_MS(REP), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    assign obs = {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse};

    // Level follows the pin once it has held one value for DB samples (seen two
    // edges late); long fires on the LONG-th ms tick held after the press and
    // repeats on every REP-th tick after that.
    task automatic step();
        logic [N-1:0] s, nl;
        logic tick;
        @(posedge clk);
        if (reset) begin
            {m_d1, m_d2, m_prev_s, m_level, m_press, m_rel, m_long, m_rep} = '0;
            m_k = 0;
            for (int c = 0; c < N; c++) begin
                m_run[c] = 0;
                m_ticks[c] = 0;
            end
        end else begin
            m_k++;
            tick = (m_k % MS) == 0;
            s = m_d2;
            m_d2 = m_d1;
            m_d1 = ~btn_raw;
            for (int c = 0; c < N; c++) begin
                m_run[c] = (s[c] == m_prev_s[c]) ? m_run[c] + 1 : 1;
                nl[c] = (s[c] != m_level[c] && m_run[c] >= DB) ? s[c] : m_level[c];
                m_press[c] = nl[c] && !m_level[c];
                m_rel[c] = !nl[c] && m_level[c];
                m_long[c] = 1'b0;
                m_rep[c] = 1'b0;
                if (m_press[c]) m_ticks[c] = 0;
                if (nl[c] && m_level[c] && tick) begin
                    m_ticks[c]++;
                    m_long[c] = m_ticks[c] == LONG;
                    m_rep[c] = m_ticks[c] > LONG && (m_ticks[c] - LONG) % REP == 0;
                end
            end
            m_prev_s = s;
            m_level = nl;
        end
        exp_v = {m_level, m_press, m_rel, m_long, m_rep};
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_raw = '1;
        repeat (4) step();
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_state got=%h want=0", obs); end
        reset = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL reset_idle n=%0d got=%h want=%h", n, obs, exp_v); end
        end
        total++;
        if (btn_level !== '0) begin bad++; $display("FAIL reset_level got=%b want=0000", btn_level); end
    endtask

    task automatic test_press();
        int t_press, t_rel, width;
        t_press = 0; t_rel = 0; width = 0;
        btn_raw[0] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL press_model n=%0d got=%h want=%h", n, obs, exp_v); end
            if (press_pulse[0]) begin width++; if (t_press == 0) t_press = n; end
        end
        total++;
        if (t_press !== 12) begin bad++; $display("FAIL press_latency got=%0d want=12", t_press); end
        total++;
        if (width !== 1) begin bad++; $display("FAIL press_width got=%0d want=1", width); end
        btn_raw[0] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL release_model n=%0d got=%h want=%h", n, obs, exp_v); end
            if (release_pulse[0] && t_rel == 0) t_rel = n;
        end
        total++;
        if (t_rel !== 12) begin bad++; $display("FAIL release_latency got=%0d want=12", t_rel); end
    endtask

    task automatic test_bounce();
        int pulses, t_press, rels;
        pulses = 0; t_press = 0; rels = 0;
        for (int n = 0; n < 60; n++) begin
            if (n % 3 == 0) btn_raw[1] = ~btn_raw[1];
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL bounce_model n=%0d got=%h want=%h", n, obs, exp_v); end
            if (press_pulse[1] || release_pulse[1]) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL bounce_quiet got=%0d want=0", pulses); end
        btn_raw[1] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL bounce_settle n=%0d got=%h want=%h", n, obs, exp_v); end
            if (press_pulse[1] && t_press == 0) t_press = n;
        end
        total++;
        if (t_press !== 12) begin bad++; $display("FAIL bounce_press got=%0d want=12", t_press); end
        btn_raw[1] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL bounce_release n=%0d got=%h want=%h", n, obs, exp_v); end
            if (release_pulse[1]) rels++;
        end
        total++;
        if (rels !== 1) begin bad++; $display("FAIL bounce_rel_count got=%0d want=1", rels); end
    endtask

    task automatic test_long();
        int t_press, t_long, n_long, n_rep, rels, late_rep;
        int reps[8];
        t_press = 0; t_long = 0; n_long = 0; n_rep = 0; rels = 0; late_rep = 0;
        btn_raw[2] = 1'b0;
        for (int n = 1; n <= 160; n++) begin
            if (n == 121) btn_raw[2] = 1'b1;
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL long_model n=%0d got=%h want=%h", n, obs, exp_v); end
            if (press_pulse[2] && t_press == 0) t_press = n;
            if (long_pulse[2]) begin n_long++; t_long = n; end
            if (repeat_pulse[2]) begin
                if (rels != 0) late_rep++;
                if (n_rep < 8) reps[n_rep] = n;
                n_rep++;
            end
            if (release_pulse[2]) rels++;
        end
        total++;
        if (n_long !== 1) begin bad++; $display("FAIL long_count got=%0d want=1", n_long); end
        total++;
        if (t_long - t_press < 40 || t_long - t_press > 50)
            begin bad++; $display("FAIL long_delay got=%0d want=40..50", t_long - t_press); end
        total++;
        if (n_rep < 2 || reps[0] - t_long != 20 || reps[1] - t_long != 40)
            begin bad++; $display("FAIL repeat_spacing got n=%0d r0=%0d r1=%0d want r0=20 r1=40", n_rep, reps[0] - t_long, reps[1] - t_long); end
        total++;
        if (rels !== 1 || late_rep !== 0) begin bad++; $display("FAIL long_release got rel=%0d late=%0d want 1/0", rels, late_rep); end
    endtask

    task automatic test_simultaneous();
        logic saw_press, saw_long, side;
        saw_press = 0; saw_long = 0; side = 0;
        btn_raw[0] = 1'b0;
        btn_raw[3] = 1'b0;
        for (int n = 1; n <= 90; n++) begin
            if (n == 70) begin btn_raw[0] = 1'b1; btn_raw[3] = 1'b1; end
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL simul_model n=%0d got=%h want=%h", n, obs, exp_v); end
            if (press_pulse == 4'b1001) saw_press = 1;
            if (long_pulse == 4'b1001) saw_long = 1;
            if (((btn_level | press_pulse | release_pulse | long_pulse | repeat_pulse) & 4'b0110) != 0) side = 1;
        end
        total++;
        if (!saw_press || !saw_long || side)
            begin bad++; $display("FAIL simul_events got press=%b long=%b side=%b want 1/1/0", saw_press, saw_long, side); end
    endtask

    task automatic test_reset_mid();
        int t_press, t_long;
        t_press = 0; t_long = 0;
        btn_raw[2] = 1'b0;
        for (int n = 1; n <= 42; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL mid_model n=%0d got=%h want=%h", n, obs, exp_v); end
        end
        reset = 1'b1;
        step();
        total++;
        if (obs !== '0) begin bad++; $display("FAIL mid_reset got=%h want=0", obs); end
        repeat (2) step();
        reset = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL mid_after n=%0d got=%h want=%h", n, obs, exp_v); end
            if (press_pulse[2] && t_press == 0) t_press = n;
            if (long_pulse[2] && t_long == 0) t_long = n;
        end
        total++;
        if (t_press !== 12) begin bad++; $display("FAIL mid_press got=%0d want=12", t_press); end
        total++;
        if (t_long - t_press < 40 || t_long - t_press > 50)
            begin bad++; $display("FAIL mid_long_restart got=%0d want=40..50", t_long - t_press); end
        btn_raw[2] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL mid_release n=%0d got=%h want=%h", n, obs, exp_v); end
        end
    endtask

    task automatic test_random();
        int rate;
        for (int n = 0; n < 3000; n++) begin
            rate = ((n / 500) % 2 == 1) ? 200 : 8;
            for (int c = 0; c < N; c++)
                if ($urandom_range(rate - 1, 0) == 0) btn_raw[c] = ~btn_raw[c];
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL random_model n=%0d got=%h want=%h", n, obs, exp_v); end
        end
        btn_raw = '1;
        for (int n = 0; n < 40; n++) begin
            step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL random_drain n=%0d got=%h want=%h", n, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_long();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
